// File: rtl/host_api_pkg.sv
// Shared command codes and FSM state encoding for the host command controller.
package host_api_pkg;

  typedef enum logic [5:0] {
    CMD_SET_OFFSET = 6'd1,
    CMD_STATUS     = 6'd2,
    CMD_RUN        = 6'd3,
    CMD_SET_PTR    = 6'd5,
    CMD_WRITE_INC  = 6'd6,
    CMD_READ_INC   = 6'd7
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/api_timeout.sv
// Access watchdog: counts cycles after start and flags expiry on the TIMEOUT-th cycle.
module api_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_reg;
  logic          run_reg;

  // count_reg is 0 during the first waiting cycle, so expiry lands on cycle TIMEOUT
  assign expired = run_reg && (count_reg == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      run_reg   <= 1'b0;
    end else if (start) begin
      count_reg <= '0;
      run_reg   <= 1'b1;
    end else if (stop) begin
      run_reg   <= 1'b0;
    end else if (run_reg && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/host_api_ctrl.sv
// Host command controller: offset/pointer registers and SDRAM word access.
// Define API_READBACK_EN to enable cmd 7 READ_INC (SDRAM read at pointer).
module host_api_ctrl
  import host_api_pkg::*;
#(
  parameter int ADDR_BITS   = 22,
  parameter int NUM_REGIONS = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid,
  input  logic [5:0]                            req_cmd,
  input  logic [31:0]                           req_arg,
  output logic                                  resp_valid,
  output logic                                  resp_err,
  output logic [31:0]                           resp_arg,
  output logic                                  ram_req,
  output logic                                  ram_we,
  output logic [ADDR_BITS-1:0]                  ram_addr,
  output logic [15:0]                           ram_wdata,
  input  logic                                  ram_ack,
  input  logic [15:0]                           ram_rdata,
  output logic                                  ram_refresh,
  output logic [NUM_REGIONS-1:0][ADDR_BITS-1:0] offsets,
  output logic                                  load_state
);

  state_e                 state_reg, state_next;
  logic [ADDR_BITS-1:0]   ptr_reg, ptr_next;
  logic                   load_reg, load_next;
  logic                   overrun_reg, overrun_next;
  logic                   resp_err_reg, resp_err_next;
  logic [31:0]            resp_arg_reg, resp_arg_next;
  logic                   ram_req_reg, ram_req_next;
  logic [ADDR_BITS-1:0]   ram_addr_reg, ram_addr_next;
  logic [15:0]            ram_wdata_reg, ram_wdata_next;
  logic [ADDR_BITS-1:0]   offset_reg [NUM_REGIONS];

  logic                   off_we;
  logic [3:0]             off_idx;
  logic [4:0]             off_shift;
  logic [ADDR_BITS-1:0]   off_val;
  logic                   off_ok;
  logic [23:0]            ptr24;
  logic                   tmo_start, tmo_stop, tmo_expired;
  logic                   unused_inputs;

  assign off_idx   = req_arg[31:28];
  assign off_shift = req_arg[4:0];
  assign off_ok    = (int'(off_idx) < NUM_REGIONS) && (int'(off_shift) < ADDR_BITS);
  assign off_val   = (off_shift == 5'd0) ? '0
                   : ({{(ADDR_BITS-1){1'b0}}, 1'b1} << off_shift);

  generate
    if (ADDR_BITS >= 24) begin : g_ptr_trunc
      assign ptr24 = ptr_reg[23:0];
    end else begin : g_ptr_ext
      assign ptr24 = {{(24-ADDR_BITS){1'b0}}, ptr_reg};
    end
  endgenerate

  api_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .start   (tmo_start),
    .stop    (tmo_stop),
    .expired (tmo_expired)
  );

`ifdef API_READBACK_EN
  logic ram_we_reg, ram_we_next;
  assign ram_we = ram_we_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ram_we_reg <= 1'b0;
    else     ram_we_reg <= ram_we_next;
  end
`else
  assign ram_we = 1'b1;
`endif

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    load_next      = load_reg;
    overrun_next   = overrun_reg;
    resp_err_next  = resp_err_reg;
    resp_arg_next  = resp_arg_reg;
    ram_req_next   = ram_req_reg;
    ram_addr_next  = ram_addr_reg;
    ram_wdata_next = ram_wdata_reg;
`ifdef API_READBACK_EN
    ram_we_next    = ram_we_reg;
`endif
    off_we         = 1'b0;
    tmo_start      = 1'b0;
    tmo_stop       = 1'b0;

    // Requests arriving while busy are dropped but remembered
    if (req_valid && state_reg != IDLE) overrun_next = 1'b1;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next    = RESP;
          resp_err_next = 1'b0;
          resp_arg_next = '0;
          case (req_cmd)
            CMD_SET_OFFSET: begin
              if (off_ok) begin
                off_we    = 1'b1;
                load_next = 1'b1;
              end else begin
                resp_err_next = 1'b1;
              end
            end
            CMD_STATUS: begin
              resp_arg_next = {overrun_reg, load_reg, 6'b0, ptr24};
              overrun_next  = 1'b0;
            end
            CMD_RUN:     load_next = 1'b0;
            CMD_SET_PTR: ptr_next  = req_arg[ADDR_BITS-1:0];
            CMD_WRITE_INC: begin
              state_next     = ACCESS;
              ram_req_next   = 1'b1;
              ram_addr_next  = ptr_reg;
              ram_wdata_next = req_arg[15:0];
`ifdef API_READBACK_EN
              ram_we_next    = 1'b1;
`endif
              tmo_start      = 1'b1;
            end
`ifdef API_READBACK_EN
            CMD_READ_INC: begin
              state_next     = ACCESS;
              ram_req_next   = 1'b1;
              ram_we_next    = 1'b0;
              ram_addr_next  = ptr_reg;
              ram_wdata_next = '0;
              tmo_start      = 1'b1;
            end
`endif
            default: resp_err_next = 1'b1;
          endcase
        end
      end
      ACCESS: begin
        // A late ack wins over expiry in the same cycle
        if (ram_ack) begin
          state_next   = RESP;
          ram_req_next = 1'b0;
          ptr_next     = ptr_reg + 1'b1;
          tmo_stop     = 1'b1;
`ifdef API_READBACK_EN
          if (!ram_we_reg) resp_arg_next = {16'b0, ram_rdata};
`endif
        end else if (tmo_expired) begin
          state_next    = RESP;
          ram_req_next  = 1'b0;
          resp_err_next = 1'b1;
          tmo_stop      = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      load_reg      <= 1'b1;
      overrun_reg   <= 1'b0;
      resp_err_reg  <= 1'b0;
      resp_arg_reg  <= '0;
      ram_req_reg   <= 1'b0;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      load_reg      <= load_next;
      overrun_reg   <= overrun_next;
      resp_err_reg  <= resp_err_next;
      resp_arg_reg  <= resp_arg_next;
      ram_req_reg   <= ram_req_next;
      ram_addr_reg  <= ram_addr_next;
      ram_wdata_reg <= ram_wdata_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGIONS; i++) offset_reg[i] <= '0;
    end else if (off_we) begin
      for (int i = 0; i < NUM_REGIONS; i++)
        if (off_idx == 4'(i)) offset_reg[i] <= off_val;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_offsets
      assign offsets[gi] = offset_reg[gi];
    end
  endgenerate

  assign resp_valid    = (state_reg == RESP);
  assign resp_err      = resp_err_reg;
  assign resp_arg      = resp_arg_reg;
  assign ram_req       = ram_req_reg;
  assign ram_addr      = ram_addr_reg;
  assign ram_wdata     = ram_wdata_reg;
  assign ram_refresh   = ~ram_req_reg;
  assign load_state    = load_reg;
  assign unused_inputs = ^{req_arg, ram_rdata};

endmodule
